// File: rtl/axil_host_req_bridge_pkg.sv
// Shared types for the AXI-lite host request bridge.
// Holds the FSM states, the request/response packets and the AXI resp codes.
package axil_host_req_bridge_pkg;

  localparam int unsigned ReqWidth  = 67;
  localparam int unsigned RespWidth = 33;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_RESP
  } state_e;

  typedef struct packed {
    logic        w;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_pkt_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_pkt_t;

endpackage

// File: rtl/axil_bridge_timeout.sv
// Clearable, enabled up-counter that saturates at cycles_p-1.
// Ports: clear_i zeroes the count, en_i advances it, tc_o flags terminal count.
module axil_bridge_timeout #(
  parameter int cycles_p = 1024,
  localparam int W = $clog2(cycles_p)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(cycles_p - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axil_host_req_bridge.sv
// AXI-lite slave to single-packet request bridge, one transaction in flight.
// Ports: s_axil_* AXI-lite slave, req_* request out, resp_* response in.
module axil_host_req_bridge
  import axil_host_req_bridge_pkg::*;
#(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 30,
  parameter int timeout_cycles_p  = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [axil_addr_width_p-1:0] s_axil_awaddr_i,
  input  logic [2:0]                   s_axil_awprot_i,
  input  logic                         s_axil_awvalid_i,
  output logic                         s_axil_awready_o,
  input  logic [axil_data_width_p-1:0] s_axil_wdata_i,
  input  logic [3:0]                   s_axil_wstrb_i,
  input  logic                         s_axil_wvalid_i,
  output logic                         s_axil_wready_o,
  output logic [1:0]                   s_axil_bresp_o,
  output logic                         s_axil_bvalid_o,
  input  logic                         s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
  input  logic [2:0]                   s_axil_arprot_i,
  input  logic                         s_axil_arvalid_i,
  output logic                         s_axil_arready_o,
  output logic [axil_data_width_p-1:0] s_axil_rdata_o,
  output logic [1:0]                   s_axil_rresp_o,
  output logic                         s_axil_rvalid_o,
  input  logic                         s_axil_rready_i,
  output logic                         req_v_o,
  output logic [ReqWidth-1:0]          req_o,
  input  logic                         req_ready_i,
  input  logic                         resp_v_i,
  input  logic [RespWidth-1:0]         resp_i,
  output logic                         resp_ready_and_o
);

  state_e   state_q, state_d;
  req_pkt_t req_q, req_d;
  logic [axil_data_width_p-1:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;
  logic stale_q, stale_d;
  logic rr_q, rr_d;

  logic [29:0] aw_addr, ar_addr;
  resp_pkt_t   resp;
  logic wr_cand, rd_cand, both;
  logic cnt_clear, cnt_en, cnt_tc;
  logic unused;

  assign aw_addr = 30'(s_axil_awaddr_i);
  assign ar_addr = 30'(s_axil_araddr_i);
  assign resp    = resp_i;
  assign unused  = ^{s_axil_awprot_i, s_axil_arprot_i,
                     aw_addr[1:0], ar_addr[1:0]};

  // Stale reads are blocked until the late response is drained.
  assign wr_cand = s_axil_awvalid_i & s_axil_wvalid_i;
  assign rd_cand = s_axil_arvalid_i & ~stale_q;
  assign both    = wr_cand & rd_cand;

  assign req_v_o = (state_q == S_WR_REQ) | (state_q == S_RD_REQ);
  assign req_o   = req_q;
  assign resp_ready_and_o = stale_q | (state_q == S_RD_WAIT);

  assign s_axil_bvalid_o = (state_q == S_WR_RESP);
  assign s_axil_bresp_o  = RESP_OKAY;
  assign s_axil_rvalid_o = (state_q == S_RD_RESP);
  assign s_axil_rdata_o  = rdata_q;
  assign s_axil_rresp_o  = rresp_q;

  axil_bridge_timeout #(
    .cycles_p(timeout_cycles_p)
  ) u_timeout (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(cnt_clear),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    stale_d = stale_q;
    rr_d    = rr_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    s_axil_awready_o = 1'b0;
    s_axil_wready_o  = 1'b0;
    s_axil_arready_o = 1'b0;

    if (stale_q && resp_v_i) begin
      stale_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (wr_cand && (!rd_cand || !rr_q)) begin
          s_axil_awready_o = 1'b1;
          s_axil_wready_o  = 1'b1;
          req_d.w    = 1'b1;
          req_d.addr = {aw_addr[29:2], 2'b00};
          req_d.data = s_axil_wdata_i;
          req_d.mask = s_axil_wstrb_i;
          if (both) rr_d = ~rr_q;
          state_d = S_WR_REQ;
        end else if (rd_cand) begin
          s_axil_arready_o = 1'b1;
          req_d.w    = 1'b0;
          req_d.addr = {ar_addr[29:2], 2'b00};
          req_d.data = '0;
          req_d.mask = 4'hF;
          if (both) rr_d = ~rr_q;
          state_d = S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        if (req_ready_i) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (s_axil_bready_i) state_d = S_IDLE;
      end
      S_RD_REQ: begin
        if (req_ready_i) begin
          cnt_clear = 1'b1;
          state_d   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        cnt_en = 1'b1;
        // A response in the terminal-count cycle beats the timeout.
        if (resp_v_i) begin
          rdata_d = resp.data;
          rresp_d = resp.err ? RESP_SLVERR : RESP_OKAY;
          state_d = S_RD_RESP;
        end else if (cnt_tc) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          stale_d = 1'b1;
          state_d = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (s_axil_rready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      stale_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      stale_q <= stale_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_axil_host_req_bridge.sv
// Directed bench for axil_host_req_bridge (timeout_cycles_p = 16).
// One task per scenario with inline checks and a final summary line.
module tb_axil_host_req_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [29:0] awaddr, araddr;
  logic        awvalid, wvalid, arvalid;
  logic        awready, wready, arready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, rvalid, rready;
  logic        req_v, req_ready, resp_v, resp_ready;
  logic [66:0] req;
  logic [32:0] resp;
  logic [6:0]  hs_bus;

  int tests_run = 0;
  int tests_failed = 0;

  assign hs_bus = {req_v, awready, wready, arready,
                   bvalid, rvalid, resp_ready};

  axil_host_req_bridge #(
    .axil_data_width_p(32),
    .axil_addr_width_p(30),
    .timeout_cycles_p (16)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .s_axil_awaddr_i (awaddr),
    .s_axil_awprot_i (3'b000),
    .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i  (wdata),
    .s_axil_wstrb_i  (wstrb),
    .s_axil_wvalid_i (wvalid),
    .s_axil_wready_o (wready),
    .s_axil_bresp_o  (bresp),
    .s_axil_bvalid_o (bvalid),
    .s_axil_bready_i (bready),
    .s_axil_araddr_i (araddr),
    .s_axil_arprot_i (3'b000),
    .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o  (rdata),
    .s_axil_rresp_o  (rresp),
    .s_axil_rvalid_o (rvalid),
    .s_axil_rready_i (rready),
    .req_v_o         (req_v),
    .req_o           (req),
    .req_ready_i     (req_ready),
    .resp_v_i        (resp_v),
    .resp_i          (resp),
    .resp_ready_and_o(resp_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    tick();
    tick();
    tests_run++;
    if (hs_bus !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_hs: got %b want 0000000", hs_bus);
    end
    tests_run++;
    if (req !== 67'd0 || rdata !== 32'd0 ||
        bresp !== 2'b00 || rresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_data: req %h rdata %h bresp %b rresp %b want 0",
               req, rdata, bresp, rresp);
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_write;
    logic [66:0] exp;
    exp = {1'b1, 30'h0000_1000, 32'hCAFEF00D, 4'b0110};
    req_ready = 1'b1;
    bready = 1'b0;
    awaddr = 30'h0000_1003;
    wdata = 32'hCAFEF00D;
    wstrb = 4'b0110;
    awvalid = 1'b1;
    wvalid = 1'b1;
    #1;
    tests_run++;
    if ({awready, wready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL wr_accept: got %b want 11", {awready, wready});
    end
    tick();
    awvalid = 1'b0;
    wvalid = 1'b0;
    tests_run++;
    if (req_v !== 1'b1 || req !== exp) begin
      tests_failed++;
      $display("FAIL wr_req: v %b pkt %h want 1 %h", req_v, req, exp);
    end
    tick();
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || req_v !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_b: bvalid %b bresp %b reqv %b want 1 00 0",
               bvalid, bresp, req_v);
    end
    tick();
    tests_run++;
    if (bvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_b_hold: got %b want 1", bvalid);
    end
    bready = 1'b1;
    tick();
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_b_done: got %b want 0", bvalid);
    end
    bready = 1'b0;
  endtask

  task automatic test_read(input logic err, input logic [31:0] d);
    logic [66:0] exp;
    logic [1:0]  exp_resp;
    exp = {1'b0, 30'h40, 32'h0, 4'hF};
    exp_resp = err ? 2'b10 : 2'b00;
    req_ready = 1'b1;
    rready = 1'b0;
    araddr = 30'h40;
    arvalid = 1'b1;
    #1;
    tests_run++;
    if (arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_accept: got %b want 1", arready);
    end
    tick();
    arvalid = 1'b0;
    tests_run++;
    if (req_v !== 1'b1 || req !== exp) begin
      tests_failed++;
      $display("FAIL rd_req: v %b pkt %h want 1 %h", req_v, req, exp);
    end
    tick();
    tick();
    tick();
    resp = {err, d};
    resp_v = 1'b1;
    tests_run++;
    if (resp_ready !== 1'b1 || rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_wait: rdy %b rvalid %b want 1 0",
               resp_ready, rvalid);
    end
    tick();
    resp_v = 1'b0;
    tests_run++;
    if (rvalid !== 1'b1 || rdata !== d || rresp !== exp_resp) begin
      tests_failed++;
      $display("FAIL rd_r: v %b data %h resp %b want 1 %h %b",
               rvalid, rdata, rresp, d, exp_resp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    tests_run++;
    if (rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_r_done: got %b want 0", rvalid);
    end
  endtask

  task automatic test_arbitration;
    int n;
    logic [5:0] seq;
    n = 0;
    seq = '0;
    req_ready = 1'b1;
    bready = 1'b1;
    rready = 1'b1;
    awaddr = 30'h100;
    araddr = 30'h200;
    wdata = 32'h1111_2222;
    wstrb = 4'hF;
    resp = {1'b0, 32'h55AA55AA};
    resp_v = 1'b1;
    awvalid = 1'b1;
    wvalid = 1'b1;
    arvalid = 1'b1;
    for (int c = 0; c < 60 && n < 3; c++) begin
      #1;
      if (awready && wready) begin
        seq = {seq[3:0], 2'd1};
        n++;
      end else if (arready) begin
        seq = {seq[3:0], 2'd2};
        n++;
      end
      tick();
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    arvalid = 1'b0;
    resp_v = 1'b0;
    tests_run++;
    if (n != 3 || seq !== 6'b01_10_01) begin
      tests_failed++;
      $display("FAIL arb_order: grants %0d seq %b want 3 011001", n, seq);
    end
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if ({req_v, bvalid, rvalid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL arb_drain: got %b want 000", {req_v, bvalid, rvalid});
    end
    awvalid = 1'b1;
    wvalid = 1'b0;
    #1;
    tests_run++;
    if ({awready, wready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL aw_only: got %b want 00", {awready, wready});
    end
    tick();
    tick();
    tests_run++;
    if (req_v !== 1'b0 || awready !== 1'b0) begin
      tests_failed++;
      $display("FAIL aw_only_hold: reqv %b awready %b want 0 0",
               req_v, awready);
    end
    awvalid = 1'b0;
    bready = 1'b0;
    rready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [66:0] exp;
    logic bad;
    bad = 1'b0;
    exp = {1'b1, 30'h0000_0ABC, 32'h0BAD_CAFE, 4'b1001};
    req_ready = 1'b0;
    bready = 1'b1;
    awaddr = 30'h0000_0ABE;
    wdata = 32'h0BAD_CAFE;
    wstrb = 4'b1001;
    awvalid = 1'b1;
    wvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_v !== 1'b1 || req !== exp || bvalid !== 1'b0) bad = 1'b1;
      tick();
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL bp_hold: reqv %b pkt %h bvalid %b want 1 %h 0",
               req_v, req, bvalid, exp);
    end
    req_ready = 1'b1;
    #1;
    tests_run++;
    if (bvalid !== 1'b0 || req_v !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_cycle: bvalid %b reqv %b want 0 1",
               bvalid, req_v);
    end
    tick();
    tests_run++;
    if (bvalid !== 1'b1 || req_v !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_b: bvalid %b reqv %b want 1 0", bvalid, req_v);
    end
    tick();
    bready = 1'b0;
  endtask

  task automatic test_timeout;
    logic early, bad;
    early = 1'b0;
    bad = 1'b0;
    req_ready = 1'b1;
    rready = 1'b0;
    araddr = 30'h80;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (rvalid !== 1'b0) early = 1'b1;
      tick();
    end
    tests_run++;
    if (early || rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL to_r: early %b v %b resp %b data %h want 0 1 10 0",
               early, rvalid, rresp, rdata);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    arvalid = 1'b1;
    #1;
    tests_run++;
    if (resp_ready !== 1'b1 || arready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_idle: rdy %b arready %b want 1 0",
               resp_ready, arready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (arready !== 1'b0 || req_v !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL stale_block: arready %b reqv %b want 0 0",
               arready, req_v);
    end
    awaddr = 30'h2000;
    wdata = 32'h600D_600D;
    wstrb = 4'hF;
    bready = 1'b1;
    awvalid = 1'b1;
    wvalid = 1'b1;
    #1;
    tests_run++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_wr_accept: aw %b ar %b want 1 0",
               awready, arready);
    end
    tick();
    awvalid = 1'b0;
    wvalid = 1'b0;
    tick();
    tests_run++;
    if (bvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_wr_b: got %b want 1", bvalid);
    end
    tick();
    bready = 1'b0;
    resp = {1'b0, 32'hFFFF_0000};
    resp_v = 1'b1;
    #1;
    tests_run++;
    if (arready !== 1'b0 || resp_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_late: ar %b rdy %b want 0 1", arready, resp_ready);
    end
    tick();
    resp_v = 1'b0;
    tests_run++;
    if (resp_ready !== 1'b0 || arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_clear: rdy %b ar %b want 0 1", resp_ready, arready);
    end
    tick();
    arvalid = 1'b0;
    tests_run++;
    if (req_v !== 1'b1 || req !== {1'b0, 30'h80, 32'h0, 4'hF}) begin
      tests_failed++;
      $display("FAIL stale_rd_req: v %b pkt %h", req_v, req);
    end
    tick();
    for (int i = 0; i < 15; i++) tick();
    resp = {1'b0, 32'h0BAD_F00D};
    resp_v = 1'b1;
    tick();
    resp_v = 1'b0;
    tests_run++;
    if (rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== 32'h0BAD_F00D) begin
      tests_failed++;
      $display("FAIL tc_resp_wins: v %b resp %b data %h want 1 00 0badf00d",
               rvalid, rresp, rdata);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    tests_run++;
    if (resp_ready !== 1'b0 || rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL tc_no_stale: rdy %b v %b want 0 0", resp_ready, rvalid);
    end
  endtask

  task automatic test_reset_mid;
    logic bad;
    bad = 1'b0;
    req_ready = 1'b1;
    rready = 1'b1;
    araddr = 30'h44;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    tests_run++;
    if (hs_bus !== 7'b0 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_rdwait: hs %b rdata %h want 0 0", hs_bus, rdata);
    end
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rvalid !== 1'b0 || req_v !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL rst_rdwait_quiet: rvalid %b reqv %b want 0 0",
               rvalid, req_v);
    end
    rready = 1'b0;
    bready = 1'b0;
    awaddr = 30'h300;
    wdata = 32'h1234_0000;
    wstrb = 4'h3;
    awvalid = 1'b1;
    wvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b0;
    tick();
    tests_run++;
    if (bvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_wr_setup: bvalid %b want 1", bvalid);
    end
    reset_i = 1'b1;
    tick();
    tests_run++;
    if (hs_bus !== 7'b0) begin
      tests_failed++;
      $display("FAIL rst_wrresp: hs %b want 0000000", hs_bus);
    end
    reset_i = 1'b0;
    tick();
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wrresp_quiet: bvalid %b want 0", bvalid);
    end
    bready = 1'b1;
    awaddr = 30'h0000_0305;
    wdata = 32'hA5A5_5A5A;
    wstrb = 4'b1100;
    awvalid = 1'b1;
    wvalid = 1'b1;
    #1;
    tests_run++;
    if ({awready, wready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL post_rst_accept: got %b want 11", {awready, wready});
    end
    tick();
    awvalid = 1'b0;
    wvalid = 1'b0;
    tests_run++;
    if (req_v !== 1'b1 ||
        req !== {1'b1, 30'h0000_0304, 32'hA5A5_5A5A, 4'b1100}) begin
      tests_failed++;
      $display("FAIL post_rst_req: v %b pkt %h", req_v, req);
    end
    tick();
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL post_rst_b: v %b resp %b want 1 00", bvalid, bresp);
    end
    tick();
    bready = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    awaddr = '0;
    araddr = '0;
    awvalid = 1'b0;
    wvalid = 1'b0;
    arvalid = 1'b0;
    wdata = '0;
    wstrb = '0;
    bready = 1'b0;
    rready = 1'b0;
    req_ready = 1'b0;
    resp_v = 1'b0;
    resp = '0;
    test_reset();
    test_write();
    test_read(1'b0, 32'h12345678);
    test_read(1'b1, 32'hDEADBEEF);
    test_arbitration();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/axil_host_req_bridge.md
Name: axil_host_req_bridge

Overview:
- Sits directly downstream of the s01 AXI-lite slave port of the Zynq shell; terminates host (PS) AXI-lite reads and writes.
- Converts each transaction into a single request packet on a valid/ready interface toward the accelerator fabric.
- Read responses return on a packet interface and are mapped back to AXI-lite R beats.
- One transaction outstanding; a response timeout guarantees the PS bus never hangs.

Parameters:
- axil_data_width_p, 32, AXI-lite data width (only 32 supported).
- axil_addr_width_p, 30, AXI-lite address width.
- timeout_cycles_p, 1024, read-response wait limit in clk_i cycles, >=2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- s_axil_awaddr_i  in  axil_addr_width_p  write address.
- s_axil_awprot_i  in  3  ignored.
- s_axil_awvalid_i  in  1  AW valid.
- s_axil_awready_o  out  1  AW ready.
- s_axil_wdata_i  in  32  write data.
- s_axil_wstrb_i  in  4  byte strobes.
- s_axil_wvalid_i  in  1  W valid.
- s_axil_wready_o  out  1  W ready.
- s_axil_bresp_o  out  2  write response.
- s_axil_bvalid_o  out  1  B valid.
- s_axil_bready_i  in  1  B ready.
- s_axil_araddr_i  in  axil_addr_width_p  read address.
- s_axil_arprot_i  in  3  ignored.
- s_axil_arvalid_i  in  1  AR valid.
- s_axil_arready_o  out  1  AR ready.
- s_axil_rdata_o  out  32  read data.
- s_axil_rresp_o  out  2  read response.
- s_axil_rvalid_o  out  1  R valid.
- s_axil_rready_i  in  1  R ready.
- req_v_o  out  1  request valid.
- req_o  out  67  request packet {w(1), addr(30), data(32), mask(4)}.
- req_ready_i  in  1  request ready.
- resp_v_i  in  1  response valid.
- resp_i  in  33  response packet {err(1), data(32)}.
- resp_ready_and_o  out  1  response ready.

Behaviour:
- Interface decision: one clock, clk_i; reset_i is synchronous and active-high.
- Reset values:
  - All valid and ready outputs are 0.
  - req_o, s_axil_rdata_o, s_axil_bresp_o and s_axil_rresp_o are 0.
  - FSM enters IDLE; stale_r=0; rr_r=0 (write favoured).
  - Reset asserted mid-transaction abandons it silently, with no B or R beat.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- IDLE write candidate: awvalid&wvalid both high. awready=wready=1 in the same cycle; they never handshake separately.
- IDLE read candidate: arvalid & ~stale_r.
- Both candidates present: rr_r picks (0 = write). rr_r toggles after every grant made while both were present.
- Accept cycle N:
  - Register the packet: addr = axaddr with bits [1:0] forced 0.
  - Write: mask = wstrb, w=1.
  - Read: data=0, mask=4'hF, w=0.
  - Go to WR_REQ or RD_REQ.
- WR_REQ / RD_REQ:
  - req_v_o=1 from cycle N+1, held until req_ready_i; req_o stable while valid.
  - WR_REQ goes to WR_RESP; RD_REQ goes to RD_WAIT, clearing the timeout counter.
- WR_RESP:
  - Writes are posted: bvalid=1, bresp=OKAY(2'b00) in the cycle after the request handshake.
  - bvalid holds until bready; then IDLE.
- RD_WAIT:
  - resp_ready_and_o=1; the counter increments each cycle.
  - On resp_v_i: capture data; rresp = err ? SLVERR(2'b10) : OKAY; go to RD_RESP.
  - If the counter reaches timeout_cycles_p-1 with no response: rdata=0, rresp=SLVERR, stale_r=1, go to RD_RESP.
  - A response arriving in that same cycle wins; no timeout fires.
- RD_RESP: rvalid holds until rready; then IDLE.
- stale_r:
  - While set, resp_ready_and_o=1 in every state and any response is consumed and discarded. That handshake clears stale_r.
  - Reads stay blocked in IDLE while stale_r is set; writes proceed.
- Minimum latencies:
  - Write: AW/W accept to bvalid is 2 cycles with req_ready_i held high.
  - Read: response to rvalid is 1 cycle.
- Timing constraint: no combinational path from any input to req_v_o, s_axil_bvalid_o or s_axil_rvalid_o.

Decomposition:
- Package axil_host_req_bridge_pkg holds:
  - the state enum;
  - the request and response packet structs, including their widths 67 and 33;
  - the resp codes OKAY and SLVERR.
- Sub-module axil_bridge_timeout holds the clear/enable up-counter with a terminal-count flag, width $clog2(timeout_cycles_p).

Test Plan:
- Write 0x0000_1003 data 0xCAFEF00D strb 4'b0110, req_ready_i=1 -> req_o={1,0x0000_1000,0xCAFEF00D,4'b0110} at N+1; bvalid=1, bresp=00 at N+2.
- Read 0x40 with resp {0,0x12345678} returned 3 cycles after req handshake -> rvalid the next cycle, rdata=0x12345678, rresp=00. Repeat with err=1 -> rresp=10.
- AW/W and AR valid together on three consecutive transactions -> grant order write, read, write. With AW valid but W low -> awready stays 0.
- req_ready_i held low 20 cycles -> req_v_o stays 1 with req_o constant; no B beat until the cycle after ready.
- Read with no response (timeout_cycles_p=16) -> rvalid with rresp=10, rdata=0 at cycle 16 of RD_WAIT. A new read stays blocked and a write completes. Late resp_v_i is consumed, then the blocked read issues.
- reset_i asserted in RD_WAIT and in WR_RESP -> next cycle all valid/ready outputs are 0 and the state is IDLE. A subsequent write completes normally.
